// File: rtl/cond_unit.sv
// Condition unit for the single-cycle core.
// Holds the architectural NZCV register, evaluates the instruction condition
// field against the stored flags, gates the PC/register/memory write-enables
// and feeds the stored carry back to the ALU.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Valid,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWrite,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CarryIn,
    output logic [3:0] Flags
);

    logic [3:0] flags_q, flags_d;
    logic       n_f, z_f, c_f, v_f;
    logic       condpass;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition evaluation against the stored flags only; the executing
    // instruction never sees its own ALU flags.
    always_comb begin
        condpass = 1'b0;
        case (Cond)
            4'b0000: condpass = z_f;
            4'b0001: condpass = ~z_f;
            4'b0010: condpass = c_f;
            4'b0011: condpass = ~c_f;
            4'b0100: condpass = n_f;
            4'b0101: condpass = ~n_f;
            4'b0110: condpass = v_f;
            4'b0111: condpass = ~v_f;
            4'b1000: condpass = c_f & ~z_f;
            4'b1001: condpass = ~c_f | z_f;
            4'b1010: condpass = (n_f == v_f);
            4'b1011: condpass = (n_f != v_f);
            4'b1100: condpass = ~z_f & (n_f == v_f);
            4'b1101: condpass = z_f | (n_f != v_f);
            4'b1110: condpass = 1'b1;
            default: condpass = 1'b0;  // 1111 is treated as never
        endcase
    end

    assign CondEx   = Valid & condpass;
    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;

    // Next flags: each half updates independently, only for an executing instruction.
    always_comb begin
        flags_d = flags_q;
        if (CondEx) begin
            if (FlagWrite[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagWrite[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // NZCV register; async reset drops any update pending in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flags_q <= RESET_FLAGS;
        else          flags_q <= flags_d;
    end

    assign Flags   = flags_q;
    assign CarryIn = flags_q[1];

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: a condition-code table plus hand-written
// sequences for flag update, partial writes, gating and async reset.
module tb_cond_unit;

    logic       clk;
    logic       reset_n;
    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagWrite;
    logic       PCS, RegW, MemW, NoWrite;
    logic       PCSrc, RegWrite, MemWrite, CondEx, CarryIn;
    logic [3:0] Flags;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
                           MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
                           HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
                           GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       pass;
    } vec_t;

    cond_unit #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n), .Valid(Valid), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagWrite(FlagWrite), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .CarryIn(CarryIn), .Flags(Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // advance past the next rising edge; inputs change 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Valid = 0; Cond = AL; ALUFlags = 0; FlagWrite = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    endtask

    // load NZCV through a real AL instruction with full flag write
    task automatic load_flags(input logic [3:0] f);
        idle();
        Valid = 1; Cond = AL; FlagWrite = 2'b11; ALUFlags = f;
        tick();
        idle();
    endtask

    vec_t tbl[24];

    initial begin
        tbl = '{
            '{4'b0000, EQ, 1'b0}, '{4'b0100, EQ, 1'b1}, '{4'b0000, NE, 1'b1},
            '{4'b0010, CS, 1'b1}, '{4'b0000, CC, 1'b1}, '{4'b1000, MI, 1'b1},
            '{4'b1000, PL, 1'b0}, '{4'b0001, VS, 1'b1}, '{4'b0001, VC, 1'b0},
            '{4'b0010, HI, 1'b1}, '{4'b0110, HI, 1'b0}, '{4'b0110, LS, 1'b1},
            '{4'b0010, LS, 1'b0}, '{4'b1000, LT, 1'b1}, '{4'b1000, LE, 1'b1},
            '{4'b1000, GE, 1'b0}, '{4'b1000, GT, 1'b0}, '{4'b1001, GE, 1'b1},
            '{4'b1001, GT, 1'b1}, '{4'b1101, GT, 1'b0}, '{4'b1101, LE, 1'b1},
            '{4'b0000, AL, 1'b1}, '{4'b1111, NV, 1'b0}, '{4'b0000, NV, 1'b0}
        };

        // reset state and behaviour under reset
        idle();
        reset_n = 0;
        #12;
        chk("reset_flags", Flags, 4'b0000);
        chk("reset_carry", {3'b0, CarryIn}, 4'd0);
        Valid = 1; RegW = 1; Cond = EQ;
        #1;
        chk("rst_eq_condex", {3'b0, CondEx}, 4'd0);
        chk("rst_eq_regwrite", {3'b0, RegWrite}, 4'd0);
        Cond = AL;
        #1;
        chk("rst_al_regwrite", {3'b0, RegWrite}, 4'd1);
        idle();
        @(negedge clk);
        reset_n = 1;
        tick();

        // condition table
        for (int i = 0; i < 24; i++) begin
            load_flags(tbl[i].flags);
            Valid = 1; RegW = 1; Cond = tbl[i].cond;
            #1;
            chk($sformatf("tbl%0d_flags", i), Flags, tbl[i].flags);
            chk($sformatf("tbl%0d_condex", i), {3'b0, CondEx}, {3'b0, tbl[i].pass});
            chk($sformatf("tbl%0d_regwrite", i), {3'b0, RegWrite}, {3'b0, tbl[i].pass});
            chk($sformatf("tbl%0d_carry", i), {3'b0, CarryIn}, {3'b0, tbl[i].flags[1]});
            idle();
        end

        // CMP-style: no register write, flags visible only next cycle
        load_flags(4'b0000);
        Valid = 1; Cond = AL; FlagWrite = 2'b11; NoWrite = 1; RegW = 1; ALUFlags = 4'b0100;
        #1;
        chk("cmp_regwrite", {3'b0, RegWrite}, 4'd0);
        chk("cmp_condex", {3'b0, CondEx}, 4'd1);
        chk("cmp_same_cycle_flags", Flags, 4'b0000);
        tick();
        idle();
        Valid = 1; Cond = EQ; RegW = 1;
        #1;
        chk("cmp_next_flags", Flags, 4'b0100);
        chk("cmp_next_eq", {3'b0, RegWrite}, 4'd1);
        idle();

        // partial flag writes
        load_flags(4'b1111);
        Valid = 1; Cond = AL; FlagWrite = 2'b10; ALUFlags = 4'b0000;
        tick();
        chk("partial_nz", Flags, 4'b0011);
        chk("partial_nz_carry", {3'b0, CarryIn}, 4'd1);
        FlagWrite = 2'b01; ALUFlags = 4'b0000;
        tick();
        chk("partial_cv", Flags, 4'b0000);
        chk("partial_cv_carry", {3'b0, CarryIn}, 4'd0);
        idle();

        // failed condition: no writes, no flag update
        load_flags(4'b0000);
        Valid = 1; Cond = EQ; FlagWrite = 2'b11; ALUFlags = 4'b1111; PCS = 1; MemW = 1; RegW = 1;
        #1;
        chk("fail_pcsrc", {3'b0, PCSrc}, 4'd0);
        chk("fail_memwrite", {3'b0, MemWrite}, 4'd0);
        chk("fail_regwrite", {3'b0, RegWrite}, 4'd0);
        tick();
        chk("fail_flags", Flags, 4'b0000);
        // same op with AL: all gated outputs assert
        Cond = AL;
        #1;
        chk("al_pcsrc", {3'b0, PCSrc}, 4'd1);
        chk("al_memwrite", {3'b0, MemWrite}, 4'd1);
        idle();

        // Valid=0 bubble
        load_flags(4'b0110);
        Valid = 0; Cond = AL; FlagWrite = 2'b11; ALUFlags = 4'b1001; PCS = 1; RegW = 1; MemW = 1;
        #1;
        chk("bub_condex", {3'b0, CondEx}, 4'd0);
        chk("bub_outs", {1'b0, PCSrc, RegWrite, MemWrite}, 4'd0);
        tick();
        chk("bub_flags", Flags, 4'b0110);
        idle();

        // async reset mid-cycle drops the pending update
        load_flags(4'b1111);
        Valid = 1; Cond = AL; FlagWrite = 2'b11; ALUFlags = 4'b0101;
        #2;
        reset_n = 0;
        #1;
        chk("async_rst_flags", Flags, 4'b0000);
        chk("async_rst_carry", {3'b0, CarryIn}, 4'd0);
        tick();
        chk("rst_held_flags", Flags, 4'b0000);
        reset_n = 1;
        tick();
        chk("first_edge_update", Flags, 4'b0101);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
